// File: rtl/fetch_decode_skid_reg_if.sv
// fetch_decode_skid_reg_if
//   Handshake bundle between instruction fetch and decode across the
//   fetch_decode_skid_reg pipeline stage.
//   Fetch side : in_valid, in_ready, in_instruction, pcplus4_in
//   Decode side: out_valid, out_ready, ins_out, pcplus4_out
//   master : environment view (drives fetch data and decode ready)
//   slave  : pipeline register view
interface fetch_decode_skid_reg_if #(
  parameter int unsigned INS_WIDTH = 32,
  parameter int unsigned PC_WIDTH  = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [INS_WIDTH-1:0] in_instruction;
  logic [PC_WIDTH-1:0]  pcplus4_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [INS_WIDTH-1:0] ins_out;
  logic [PC_WIDTH-1:0]  pcplus4_out;

  modport master (
    output in_valid, in_instruction, pcplus4_in, out_ready,
    input  in_ready, out_valid, ins_out, pcplus4_out
  );

  modport slave (
    input  in_valid, in_instruction, pcplus4_in, out_ready,
    output in_ready, out_valid, ins_out, pcplus4_out
  );
endinterface

// File: rtl/fetch_decode_skid_reg.sv
// fetch_decode_skid_reg
//   Fetch-to-decode pipeline register with valid/ready handshake and a
//   two-entry skid buffer (main + skid). Carries the instruction word and
//   PC+4. in_ready depends only on registered state and flush, so there is
//   no combinational path from out_ready to in_ready.
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   flush     : synchronous flush, empties both entries, blocks input
//   bus       : handshake bundle (slave modport)
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
//   flush_cnt : saturating count of cycles with flush asserted
module fetch_decode_skid_reg #(
  parameter int unsigned INS_WIDTH = 32,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  fetch_decode_skid_reg_if.slave bus,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]           state;
  logic [INS_WIDTH-1:0] main_ins;
  logic [PC_WIDTH-1:0]  main_pc;
  logic [INS_WIDTH-1:0] skid_ins;
  logic [PC_WIDTH-1:0]  skid_pc;
  logic                 push;
  logic                 pop;
  logic                 stall;

  assign bus.in_ready    = (state != TWO) && !flush;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.ins_out     = main_ins;
  assign bus.pcplus4_out = main_pc;

  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;
  assign stall = bus.out_valid && !bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      main_ins <= '0;
      main_pc  <= '0;
      skid_ins <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      // any same-cycle pop is simply absorbed by the clear
      state    <= EMPTY;
      main_ins <= '0;
      main_pc  <= '0;
      skid_ins <= '0;
      skid_pc  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state    <= ONE;
            main_ins <= bus.in_instruction;
            main_pc  <= bus.pcplus4_in;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ins <= bus.in_instruction;
            main_pc  <= bus.pcplus4_in;
          end else if (push) begin
            state    <= TWO;
            skid_ins <= bus.in_instruction;
            skid_pc  <= bus.pcplus4_in;
          end else if (pop) begin
            state    <= EMPTY;
            main_ins <= '0;
            main_pc  <= '0;
          end
        end
        TWO: begin
          if (pop) begin
            state    <= ONE;
            main_ins <= skid_ins;
            main_pc  <= skid_pc;
            skid_ins <= '0;
            skid_pc  <= '0;
          end
        end
        default: begin
          state    <= EMPTY;
          main_ins <= '0;
          main_pc  <= '0;
          skid_ins <= '0;
          skid_pc  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
module tb_fetch_decode_skid_reg;
  localparam int unsigned IW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  fetch_decode_skid_reg_if #(.INS_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  fetch_decode_skid_reg #(.INS_WIDTH(IW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [31:0]   ins;
    logic [31:0]   pc;
    logic          fl;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic [31:0]   e_ins;
    logic [31:0]   e_pc;
    logic [CW-1:0] e_stall;
    logic [CW-1:0] e_flush;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    bus.in_valid       = iv;
    bus.in_instruction = ins;
    bus.pcplus4_in     = pc;
    flush              = fl;
    bus.out_ready      = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [31:0] ins,
                           input logic [31:0] pc);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    check({tag, " ins_out"}, bus.ins_out, ins);
    check({tag, " pcplus4_out"}, bus.pcplus4_out, pc);
  endtask

  initial begin
    //         iv    ins    pc     fl ordy rdy ov  e_ins  e_pc  stall flush
    vecs[0]  = '{1'b1, 32'h11, 32'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 32'h04, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 32'h22, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 32'h08, 4'd0, 4'd0};
    vecs[2]  = '{1'b1, 32'h33, 32'h0C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 32'h0C, 4'd0, 4'd0};
    vecs[3]  = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 4'd0, 4'd0};
    vecs[4]  = '{1'b1, 32'hA1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 32'h10, 4'd0, 4'd0};
    vecs[5]  = '{1'b1, 32'hA2, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 32'h10, 4'd1, 4'd0};
    vecs[6]  = '{1'b1, 32'hA3, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 32'h10, 4'd2, 4'd0};
    vecs[7]  = '{1'b1, 32'hA3, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 32'h10, 4'd3, 4'd0};
    vecs[8]  = '{1'b1, 32'hA3, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA2, 32'h14, 4'd3, 4'd0};
    vecs[9]  = '{1'b1, 32'hA3, 32'h18, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3, 32'h18, 4'd3, 4'd0};
    vecs[10] = '{1'b1, 32'hA4, 32'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA4, 32'h1C, 4'd3, 4'd0};
    vecs[11] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 4'd3, 4'd0};
    vecs[12] = '{1'b1, 32'hC1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC1, 32'h20, 4'd3, 4'd0};
    vecs[13] = '{1'b1, 32'hC2, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC1, 32'h20, 4'd4, 4'd0};
    vecs[14] = '{1'b1, 32'hBB, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 4'd5, 4'd1};
    vecs[15] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 4'd5, 4'd1};
    vecs[16] = '{1'b1, 32'hD1, 32'h30, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD1, 32'h30, 4'd5, 4'd1};
    vecs[17] = '{1'b1, 32'hD2, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 4'd5, 4'd2};
    vecs[18] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 4'd5, 4'd2};
    vecs[19] = '{1'b1, 32'h55, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h40, 4'd5, 4'd2};
    vecs[20] = '{1'b1, 32'h66, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h66, 32'h44, 4'd5, 4'd2};
    vecs[21] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 4'd5, 4'd2};

    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_out("reset", 1'b0, 32'h0, 32'h0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("reset flush_cnt", {28'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // table: stream, back-pressure, flush in TWO/ONE, push+pop in ONE
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      #1;
      check($sformatf("row%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
      @(posedge clk);
      #1;
      check_out($sformatf("row%0d", i), vecs[i].e_ov, vecs[i].e_ins, vecs[i].e_pc);
      check($sformatf("row%0d stall_cnt", i), {28'd0, stall_cnt}, {28'd0, vecs[i].e_stall});
      check($sformatf("row%0d flush_cnt", i), {28'd0, flush_cnt}, {28'd0, vecs[i].e_flush});
    end

    // counter saturation: stall for 20 cycles, then flush for 20 cycles
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'hE1, 32'h60, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("sat stall_cnt", {28'd0, stall_cnt}, 32'd15);
    check_out("sat hold", 1'b1, 32'hE1, 32'h60);
    repeat (3) @(negedge clk);
    check("sat stall_cnt hold", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    repeat (20) @(negedge clk);
    flush = 1'b0;
    check("sat flush_cnt", {28'd0, flush_cnt}, 32'd15);
    check("sat stall after flush", {28'd0, stall_cnt}, 32'd15);

    // asynchronous reset between edges while in TWO
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'hF1, 32'h70, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hF2, 32'h74, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre-areset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("pre-areset stall_cnt", {28'd0, stall_cnt}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_out("areset", 1'b0, 32'h0, 32'h0);
    check("areset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("areset stall_cnt", {28'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h77, 32'h80, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_out("post-areset push", 1'b1, 32'h77, 32'h80);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_out("post-areset drain", 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_skid_reg.md
# fetch_decode_skid_reg

Parametrised fetch-to-decode pipeline register that replaces the plain stall/clear stage with a valid/ready handshake and a two-entry skid buffer. It sits between instruction fetch and decode and carries the instruction word and PC+4 across the boundary. It supports flush (bubble insertion) and back-pressure with no combinational path from the decode-side ready to the fetch-side ready. It also keeps saturating stall and flush counters for performance debug.

## Interface
- INS_WIDTH, 32, instruction word width
- PC_WIDTH, 32, PC+4 width
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_instruction  in  INS_WIDTH  fetched instruction
- pcplus4_in  in  PC_WIDTH  PC+4 of fetched instruction
- flush  in  1  synchronous flush (branch taken / hazard clear)
- out_valid  out  1  ins_out/pcplus4_out hold a valid entry
- out_ready  in  1  decode consumes the entry this cycle
- ins_out  out  INS_WIDTH  head instruction (zero when empty)
- pcplus4_out  out  PC_WIDTH  head PC+4 (zero when empty)
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_WIDTH  cycles with flush=1

## Operation
- Storage: main register (drives outputs) and skid register; state EMPTY, ONE (main full), TWO (main+skid full).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != TWO) & !flush; depends only on registered state and flush.
- out_valid = (state != EMPTY).
- EMPTY: push -> ONE, main <= input.
- ONE: push & pop -> ONE, main <= input; push & !pop -> TWO, skid <= input; !push & pop -> EMPTY, main <= 0; else hold.
- TWO: pop -> ONE, main <= skid, skid <= 0; else hold (in_ready=0).
- flush=1: state -> EMPTY; main and skid zeroed; the same-cycle input is dropped (in_ready is already 0); pop in that cycle still counts as a completed transfer for decode.
- Priority: reset > flush > handshake.
- Order is strict FIFO; no entry is duplicated or lost except by flush.
- stall_cnt increments when out_valid & !out_ready; flush_cnt increments when flush=1. Both saturate at all-ones and never wrap. Flush and stall may increment in the same cycle.

## Timing
- Reset (asynchronous, low): state EMPTY, in_ready=1 (if flush=0), out_valid=0, ins_out=0, pcplus4_out=0, skid=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: input pushed at edge N appears on ins_out/pcplus4_out after edge N; out_valid is high in cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- out_ready dropping does not lower in_ready until the cycle after the skid fills, so one extra entry is absorbed.
- in_ready returns high the cycle after the pop that leaves TWO.
- Outputs are registered; no combinational input-to-output path except flush -> in_ready.

## Test plan
- Reset then stream: in_valid=1 with instructions 0x11,0x22,0x33 and PC+4 4,8,12, out_ready=1 -> ins_out 0x11,0x22,0x33 on consecutive cycles starting 1 cycle later; in_ready stays 1; stall_cnt=0.
- Back-pressure: stream 0xA1..0xA4 with out_ready=0 from cycle 2 -> state reaches TWO holding 0xA1 (main) and 0xA2 (skid); in_ready=0; stall_cnt counts each held cycle. Raising out_ready then yields 0xA1,0xA2 in order, and 0xA3 is accepted only after in_ready returns 1.
- Flush in TWO with in_valid=1 (0xBB) -> next cycle out_valid=0, ins_out=0, pcplus4_out=0, flush_cnt=1; 0xBB is not accepted.
- Simultaneous push and pop in ONE (main 0x55, input 0x66) -> state stays ONE, ins_out=0x66.
- Counter saturation with CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
- Async reset asserted between edges while in TWO -> outputs and counters zero immediately; after release, first push appears 1 cycle later.
